// File: rtl/apb_mailbox_pkg.sv
// Shared definitions for the APB mailbox: register offsets, STATUS/CTRL bit
// positions and the APB transfer state encoding.
package apb_mailbox_pkg;

    // Register select values, taken from paddr[3:2]
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_RXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    // STATUS bit positions
    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_EMPTY   = 1;
    localparam int ST_RX_FULL    = 2;
    localparam int ST_RX_EMPTY   = 3;
    localparam int ST_TX_OVF     = 4;
    localparam int ST_RX_UDF     = 5;
    localparam int ST_TX_CNT_LSB = 8;
    localparam int ST_RX_CNT_LSB = 16;

    // CTRL bit positions
    localparam int CT_TX_FLUSH = 0;
    localparam int CT_RX_FLUSH = 1;
    localparam int CT_ERR_EN   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/apb_mailbox_completer_if.sv
// APB completer-side bus bundle for the mailbox.
interface apb_mailbox_completer_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/mailbox_fifo.sv
// Synchronous first-word-fall-through FIFO with flush. Flush has priority over
// a same-cycle push/pop and suppresses the overflow/underflow pulses.
module mailbox_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push & ~full  & ~flush;
    assign do_pop    = pop  & ~empty & ~flush;
    assign overflow  = push & full   & ~flush;
    assign underflow = pop  & empty  & ~flush;
    assign head      = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/apb_mailbox_completer.sv
// APB completer exposing a TX FIFO (CPU -> fabric stream) and an RX FIFO
// (fabric stream -> CPU). Read data and error are decided at the end of the
// WAIT cycle and presented in RESP; all state changes commit at the end of RESP.
module apb_mailbox_completer
    import apb_mailbox_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                  pclk,
    input  logic                  presetn,
    apb_mailbox_completer_if.slave apb,
    output logic [WIDTH-1:0]      m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    input  logic [WIDTH-1:0]      s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_t          state;
    state_t          state_next;
    logic [1:0]      sel;
    logic            in_wait;
    logic            in_resp;
    logic            wr_resp;
    logic            rd_resp;
    logic            tx_push, tx_pop, tx_flush;
    logic            rx_push, rx_pop, rx_flush, rx_miss;
    logic            tx_full, tx_empty, rx_full, rx_empty;
    logic [CW-1:0]   tx_count, rx_count;
    logic [WIDTH-1:0] rx_head;
    logic            tx_ovf_pulse, tx_udf_pulse, rx_ovf_pulse, rx_udf_pulse;
    logic            tx_ovf, rx_udf, err_en;
    logic [31:0]     status;
    logic [31:0]     rd_value;
    logic            err_value;
    logic [31:0]     prdata_p1;
    logic            pslverr_p1;
    logic            pready_p1;
    logic            rx_avail_p1;
    logic            unused_sink;

    assign sel     = apb.paddr[3:2];
    assign in_wait = (state == WAIT);
    assign in_resp = (state == RESP);
    assign wr_resp = in_resp & apb.psel & apb.pwrite;
    assign rd_resp = in_resp & apb.psel & ~apb.pwrite;

    // A pop is only committed if the RX FIFO had a word when the data was
    // captured, so a word arriving during WAIT is never silently consumed.
    assign tx_push  = wr_resp & (sel == REG_TXDATA);
    assign tx_flush = wr_resp & (sel == REG_CTRL) & apb.pwdata[CT_TX_FLUSH];
    assign rx_flush = wr_resp & (sel == REG_CTRL) & apb.pwdata[CT_RX_FLUSH];
    assign rx_pop   = rd_resp & (sel == REG_RXDATA) & rx_avail_p1;
    assign rx_miss  = rd_resp & (sel == REG_RXDATA) & ~rx_avail_p1;
    assign tx_pop   = m_tvalid & m_tready;
    assign rx_push  = s_tvalid & s_tready;
    assign m_tvalid = ~tx_empty;
    assign s_tready = ~rx_full;

    assign apb.prdata  = prdata_p1;
    assign apb.pslverr = pslverr_p1;
    assign apb.pready  = pready_p1;

    assign unused_sink = &{1'b0, apb.paddr[31:4], apb.paddr[1:0], tx_udf_pulse, rx_ovf_pulse};

    mailbox_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_tx_fifo (
        .clk       (pclk),
        .resetn    (presetn),
        .push      (tx_push),
        .push_data (WIDTH'(apb.pwdata)),
        .pop       (tx_pop),
        .flush     (tx_flush),
        .head      (m_tdata),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count),
        .overflow  (tx_ovf_pulse),
        .underflow (tx_udf_pulse)
    );

    mailbox_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_rx_fifo (
        .clk       (pclk),
        .resetn    (presetn),
        .push      (rx_push),
        .push_data (s_tdata),
        .pop       (rx_pop),
        .flush     (rx_flush),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count),
        .overflow  (rx_ovf_pulse),
        .underflow (rx_udf_pulse)
    );

    // Transfer state register
    always_ff @(posedge pclk) begin
        if (!presetn) state <= IDLE;
        else          state <= state_next;
    end

    // Fixed one-wait-state sequencing once an access phase is seen
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (apb.psel && apb.penable) state_next = WAIT;
            WAIT:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Read mux and error decision, sampled at the end of WAIT
    always_comb begin
        status                             = '0;
        status[ST_TX_FULL]                 = tx_full;
        status[ST_TX_EMPTY]                = tx_empty;
        status[ST_RX_FULL]                 = rx_full;
        status[ST_RX_EMPTY]                = rx_empty;
        status[ST_TX_OVF]                  = tx_ovf;
        status[ST_RX_UDF]                  = rx_udf;
        status[ST_TX_CNT_LSB +: 8]         = 8'(tx_count);
        status[ST_RX_CNT_LSB +: 8]         = 8'(rx_count);
        rd_value                           = '0;
        case (sel)
            REG_RXDATA: rd_value = 32'(rx_head);
            REG_STATUS: rd_value = status;
            REG_CTRL:   rd_value[CT_ERR_EN] = err_en;
            default:    rd_value = '0;
        endcase
        err_value = err_en & ((apb.pwrite & (sel == REG_TXDATA) & tx_full) |
                              (~apb.pwrite & (sel == REG_RXDATA) & rx_empty));
    end

    // Registered response; prdata/pslverr are zero outside RESP
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            pready_p1   <= 1'b0;
            prdata_p1   <= '0;
            pslverr_p1  <= 1'b0;
            rx_avail_p1 <= 1'b0;
        end else begin
            pready_p1   <= in_wait;
            prdata_p1   <= (in_wait && !apb.pwrite) ? rd_value : '0;
            pslverr_p1  <= in_wait & err_value;
            rx_avail_p1 <= ~rx_empty;
        end
    end

    // Sticky error flags (W1C) and the err_en control bit
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            tx_ovf <= 1'b0;
            rx_udf <= 1'b0;
            err_en <= 1'b0;
        end else begin
            if (wr_resp && sel == REG_STATUS) begin
                if (apb.pwdata[ST_TX_OVF]) tx_ovf <= 1'b0;
                if (apb.pwdata[ST_RX_UDF]) rx_udf <= 1'b0;
            end
            if (tx_ovf_pulse)            tx_ovf <= 1'b1;
            if (rx_miss || rx_udf_pulse) rx_udf <= 1'b1;
            if (wr_resp && sel == REG_CTRL) err_en <= apb.pwdata[CT_ERR_EN];
        end
    end
endmodule

// File: tb/tb_apb_mailbox_completer.sv
// Directed self-checking bench for apb_mailbox_completer.
module tb_apb_mailbox_completer;
    logic        clk = 1'b0;
    logic        presetn;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] rd;
    logic        er;

    apb_mailbox_completer_if bus ();

    apb_mailbox_completer #(.DEPTH(16), .WIDTH(32)) dut (
        .pclk     (clk),
        .presetn  (presetn),
        .apb      (bus),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One APB transfer; pready is expected in the cycle after WAIT, i.e. the
    // third cycle with penable high. fab_pop raises m_tready during RESP only.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic fab_pop, output logic [31:0] rdata, output logic err);
        int lat;
        @(posedge clk); #1;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = addr;
        bus.pwdata  = wdata;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        lat   = 0;
        rdata = '0;
        err   = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (bus.pready) begin
                lat = c;
                break;
            end
            check("prdata_while_wait", bus.prdata, 32'h0);
            check("pslverr_while_wait", {31'h0, bus.pslverr}, 32'h0);
            @(posedge clk); #1;
        end
        check("pready_latency", 32'(lat), 32'd3);
        rdata = bus.prdata;
        err   = bus.pslverr;
        if (wr) check("prdata_on_write", rdata, 32'h0);
        if (fab_pop) m_tready = 1'b1;
        @(posedge clk); #1;
        if (fab_pop) m_tready = 1'b0;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        presetn     = 1'b0;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = '0;
        bus.pwdata  = '0;
        m_tready    = 1'b0;
        s_tdata     = '0;
        s_tvalid    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pready", {31'h0, bus.pready}, 32'h0);
        check("rst_pslverr", {31'h0, bus.pslverr}, 32'h0);
        check("rst_prdata", bus.prdata, 32'h0);
        check("rst_m_tvalid", {31'h0, m_tvalid}, 32'h0);
        check("rst_m_tdata", m_tdata, 32'h0);
        check("rst_s_tready", {31'h0, s_tready}, 32'h1);
        presetn = 1'b1;

        // Both FIFOs empty after reset
        apb_xfer(1'b0, 32'h8, 32'h0, 1'b0, rd, er);
        check("status_after_reset", rd, 32'h0000_000A);
        check("status_pslverr", {31'h0, er}, 32'h0);

        // Two TX words with the fabric stalled, then drained in order
        apb_xfer(1'b1, 32'h0, 32'hDEAD_BEEF, 1'b0, rd, er);
        apb_xfer(1'b1, 32'h0, 32'h1234_5678, 1'b0, rd, er);
        apb_xfer(1'b0, 32'h8, 32'h0, 1'b0, rd, er);
        check("status_tx2", rd, 32'h0000_0208);
        check("tx_head0_valid", {31'h0, m_tvalid}, 32'h1);
        check("tx_head0", m_tdata, 32'hDEAD_BEEF);
        m_tready = 1'b1;
        @(posedge clk); #1;
        check("tx_head1", m_tdata, 32'h1234_5678);
        check("tx_head1_valid", {31'h0, m_tvalid}, 32'h1);
        @(posedge clk); #1;
        check("tx_drained_valid", {31'h0, m_tvalid}, 32'h0);
        check("tx_drained_data", m_tdata, 32'h0);
        m_tready = 1'b0;

        // Fill RX with 0..15, then read them back and underflow once
        s_tvalid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_tdata = 32'(i);
            @(posedge clk); #1;
        end
        check("rx_full_s_tready", {31'h0, s_tready}, 32'h0);
        s_tvalid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            apb_xfer(1'b0, 32'h4, 32'h0, 1'b0, rd, er);
            check("rx_word", rd, 32'(i));
        end
        check("rx_drained_s_tready", {31'h0, s_tready}, 32'h1);
        apb_xfer(1'b0, 32'h4, 32'h0, 1'b0, rd, er);
        check("rx_underflow_data", rd, 32'h0);
        check("rx_underflow_noerr", {31'h0, er}, 32'h0);
        apb_xfer(1'b0, 32'h8, 32'h0, 1'b0, rd, er);
        check("status_rx_udf", rd, 32'h0000_002A);

        // err_en=1, fill TX and overflow it
        apb_xfer(1'b1, 32'hC, 32'h4, 1'b0, rd, er);
        apb_xfer(1'b0, 32'hC, 32'h0, 1'b0, rd, er);
        check("ctrl_err_en", rd, 32'h0000_0004);
        for (int i = 0; i < 16; i++) begin
            apb_xfer(1'b1, 32'h0, 32'h100 + 32'(i), 1'b0, rd, er);
            check("tx_fill_noerr", {31'h0, er}, 32'h0);
        end
        apb_xfer(1'b1, 32'h0, 32'hBAD0_0001, 1'b0, rd, er);
        check("tx_ovf_pslverr", {31'h0, er}, 32'h1);
        apb_xfer(1'b0, 32'h8, 32'h0, 1'b0, rd, er);
        check("status_tx_ovf", rd, 32'h0000_1039);
        apb_xfer(1'b1, 32'h8, 32'h10, 1'b0, rd, er);
        check("w1c_pslverr", {31'h0, er}, 32'h0);
        apb_xfer(1'b0, 32'h8, 32'h0, 1'b0, rd, er);
        check("status_ovf_cleared", rd, 32'h0000_1029);

        // Push into a full TX in the same cycle as a fabric pop
        apb_xfer(1'b1, 32'h0, 32'hBAD0_0002, 1'b1, rd, er);
        check("push_pop_pslverr", {31'h0, er}, 32'h1);
        check("push_pop_head", m_tdata, 32'h0000_0101);
        apb_xfer(1'b0, 32'h8, 32'h0, 1'b0, rd, er);
        check("status_push_pop", rd, 32'h0000_0F38);
        apb_xfer(1'b1, 32'h8, 32'h30, 1'b0, rd, er);
        apb_xfer(1'b0, 32'h8, 32'h0, 1'b0, rd, er);
        check("status_sticky_cleared", rd, 32'h0000_0F08);

        // TX flush while the fabric keeps popping
        m_tready = 1'b1;
        apb_xfer(1'b1, 32'hC, 32'h1, 1'b0, rd, er);
        check("flush_m_tvalid", {31'h0, m_tvalid}, 32'h0);
        m_tready = 1'b0;
        apb_xfer(1'b0, 32'h8, 32'h0, 1'b0, rd, er);
        check("status_after_flush", rd, 32'h0000_000A);
        apb_xfer(1'b0, 32'hC, 32'h0, 1'b0, rd, er);
        check("ctrl_after_flush", rd, 32'h0);

        // Reset asserted while a read sits in WAIT
        apb_xfer(1'b1, 32'h0, 32'h0000_0055, 1'b0, rd, er);
        check("pre_reset_m_tvalid", {31'h0, m_tvalid}, 32'h1);
        @(posedge clk); #1;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = 32'h8;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        @(posedge clk); #1;
        check("wait_pready", {31'h0, bus.pready}, 32'h0);
        presetn = 1'b0;
        @(posedge clk); #1;
        check("midrst_pready", {31'h0, bus.pready}, 32'h0);
        check("midrst_prdata", bus.prdata, 32'h0);
        check("midrst_pslverr", {31'h0, bus.pslverr}, 32'h0);
        check("midrst_m_tvalid", {31'h0, m_tvalid}, 32'h0);
        check("midrst_m_tdata", m_tdata, 32'h0);
        check("midrst_s_tready", {31'h0, s_tready}, 32'h1);
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        @(posedge clk); #1;
        check("midrst_pready_hold", {31'h0, bus.pready}, 32'h0);
        presetn = 1'b1;
        apb_xfer(1'b0, 32'h8, 32'h0, 1'b0, rd, er);
        check("status_after_midrst", rd, 32'h0000_000A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
